// File: rtl/mem_arbiter_pkg.sv
// Shared sizes, state encoding and port indices for the scratch-memory arbiter.
package mem_arbiter_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_ARB   = 1'b1
    } arb_state_e;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the port that did not win last time is chosen.
module mem_arbiter_rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_Req,
    input  logic       i_Last,
    output logic [1:0] o_Gnt
);
    always_comb begin
        o_Gnt = 2'b00;
        case (i_Req)
            2'b01:   o_Gnt = 2'b01;
            2'b10:   o_Gnt = 2'b10;
            2'b11:   o_Gnt = (i_Last == PORT_1) ? 2'b01 : 2'b10;
            default: o_Gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Clears the 16x8 scratch memory after reset, then shares it round-robin between
// two requesters with one access per cycle; reads return one cycle after the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00,
    parameter bit                CLEAR_EN    = 1'b1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req_0,
    input  logic              i_Req_1,
    input  logic              i_We_0,
    input  logic              i_We_1,
    input  logic [ADDR_W-1:0] i_Addr_0,
    input  logic [ADDR_W-1:0] i_Addr_1,
    input  logic [DATA_W-1:0] i_Wdata_0,
    input  logic [DATA_W-1:0] i_Wdata_1,
    output logic              o_Gnt_0,
    output logic              o_Gnt_1,
    output logic              o_Rvalid_0,
    output logic              o_Rvalid_1,
    output logic [DATA_W-1:0] o_Rdata,
    output logic              o_Ready,
    output logic              o_Mem_W_En,
    output logic              o_Mem_R_En,
    output logic [ADDR_W-1:0] o_Mem_W_Addr,
    output logic [ADDR_W-1:0] o_Mem_R_Addr,
    output logic [DATA_W-1:0] o_Mem_W_Data,
    input  logic [DATA_W-1:0] i_Mem_R_Data
);
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              ready_q, ready_d;

    logic              arb_en;
    logic [1:0]        req_v;
    logic [1:0]        gnt;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Reset masks arbitration so a request held through reset is never granted.
    assign arb_en = (state_q == S_ARB) && !i_Rst;
    assign req_v  = {i_Req_1, i_Req_0} & {2{arb_en}};

    mem_arbiter_rr_pick2 u_pick (
        .i_Req  (req_v),
        .i_Last (last_q),
        .o_Gnt  (gnt)
    );

    assign sel       = gnt[1] ? PORT_1 : PORT_0;
    assign sel_we    = (sel == PORT_1) ? i_We_1    : i_We_0;
    assign sel_addr  = (sel == PORT_1) ? i_Addr_1  : i_Addr_0;
    assign sel_wdata = (sel == PORT_1) ? i_Wdata_1 : i_Wdata_0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        rvalid_d     = 2'b00;
        o_Mem_W_En   = 1'b0;
        o_Mem_R_En   = 1'b0;
        o_Mem_W_Addr = '0;
        o_Mem_R_Addr = '0;
        o_Mem_W_Data = '0;

        if (state_q == S_CLEAR && !i_Rst) begin
            o_Mem_W_En   = 1'b1;
            o_Mem_W_Addr = cnt_q;
            o_Mem_W_Data = CLEAR_VALUE;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_ARB;
            end
        end else if (gnt != 2'b00) begin
            last_d = sel;
            if (sel_we) begin
                o_Mem_W_En   = 1'b1;
                o_Mem_W_Addr = sel_addr;
                o_Mem_W_Data = sel_wdata;
            end else begin
                o_Mem_R_En   = 1'b1;
                o_Mem_R_Addr = sel_addr;
                rvalid_d     = gnt;
            end
        end

        ready_d = (state_d == S_ARB);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= CLEAR_EN ? S_CLEAR : S_ARB;
            cnt_q    <= '0;
            last_q   <= PORT_1;
            rvalid_q <= 2'b00;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
        end
    end

    assign o_Gnt_0 = gnt[0];
    assign o_Gnt_1 = gnt[1];

    // A read granted just before reset must not surface while reset is applied.
    assign o_Rvalid_0 = rvalid_q[0] && !i_Rst;
    assign o_Rvalid_1 = rvalid_q[1] && !i_Rst;
    assign o_Ready    = ready_q && !i_Rst;
    assign o_Rdata    = i_Mem_R_Data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 16x8 sync-read memory, reference memory image
// and per-port expected-read queues; a second instance runs with the clear disabled.
module tb_mem_arbiter;
    localparam logic [7:0] CLR = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic       gnt0, gnt1, rvalid0, rvalid1, ready;
    logic [7:0] rdata;
    logic       w_en, r_en;
    logic [3:0] w_addr, r_addr;
    logic [7:0] w_data;
    logic [7:0] mem_rdata;

    logic       d1_gnt0, d1_gnt1, d1_rvalid0, d1_rvalid1, d1_ready;
    logic [7:0] d1_rdata;
    logic       d1_w_en, d1_r_en;
    logic [3:0] d1_w_addr, d1_r_addr;
    logic [7:0] d1_w_data;

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [1:0] pend = 2'b00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CLEAR_VALUE(CLR), .CLEAR_EN(1'b1)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Req_0(req0), .i_Req_1(req1), .i_We_0(we0), .i_We_1(we1),
        .i_Addr_0(addr0), .i_Addr_1(addr1), .i_Wdata_0(wdata0), .i_Wdata_1(wdata1),
        .o_Gnt_0(gnt0), .o_Gnt_1(gnt1), .o_Rvalid_0(rvalid0), .o_Rvalid_1(rvalid1),
        .o_Rdata(rdata), .o_Ready(ready),
        .o_Mem_W_En(w_en), .o_Mem_R_En(r_en), .o_Mem_W_Addr(w_addr), .o_Mem_R_Addr(r_addr),
        .o_Mem_W_Data(w_data), .i_Mem_R_Data(mem_rdata)
    );

    mem_arbiter #(.CLEAR_VALUE(CLR), .CLEAR_EN(1'b0)) dut_nc (
        .i_Clk(clk), .i_Rst(rst),
        .i_Req_0(req0), .i_Req_1(req1), .i_We_0(we0), .i_We_1(we1),
        .i_Addr_0(addr0), .i_Addr_1(addr1), .i_Wdata_0(wdata0), .i_Wdata_1(wdata1),
        .o_Gnt_0(d1_gnt0), .o_Gnt_1(d1_gnt1), .o_Rvalid_0(d1_rvalid0), .o_Rvalid_1(d1_rvalid1),
        .o_Rdata(d1_rdata), .o_Ready(d1_ready),
        .o_Mem_W_En(d1_w_en), .o_Mem_R_En(d1_r_en), .o_Mem_W_Addr(d1_w_addr), .o_Mem_R_Addr(d1_r_addr),
        .o_Mem_W_Data(d1_w_data), .i_Mem_R_Data(8'h00)
    );

    // Memory instance the arbiter drives.
    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= w_data;
        if (r_en) mem_rdata <= mem[r_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected reads are queued at grant time from the reference image.
    always @(negedge clk) begin
        if (rst) begin
            check("rvalid0_rst", {31'b0, rvalid0}, 0);
            check("rvalid1_rst", {31'b0, rvalid1}, 0);
            check("gnt_rst", {30'b0, gnt1, gnt0}, 0);
            exp_q0.delete();
            exp_q1.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = CLR;
            pend = 2'b00;
        end else begin
            check("rvalid0", {31'b0, rvalid0}, {31'b0, pend[0]});
            check("rvalid1", {31'b0, rvalid1}, {31'b0, pend[1]});
            if (rvalid0) begin
                if (exp_q0.size() == 0) check("rdata0_unexp", 1, 0);
                else check("rdata0", {24'b0, rdata}, {24'b0, exp_q0.pop_front()});
            end
            if (rvalid1) begin
                if (exp_q1.size() == 0) check("rdata1_unexp", 1, 0);
                else check("rdata1", {24'b0, rdata}, {24'b0, exp_q1.pop_front()});
            end
            check("wr_rd_excl", {31'b0, w_en & r_en}, 0);
            check("gnt_excl", {31'b0, gnt0 & gnt1}, 0);
            pend = {gnt1 & ~we1, gnt0 & ~we0};
            if (gnt0) begin
                if (we0) ref_mem[addr0] = wdata0;
                else exp_q0.push_back(ref_mem[addr0]);
            end
            if (gnt1) begin
                if (we1) ref_mem[addr1] = wdata1;
                else exp_q1.push_back(ref_mem[addr1]);
            end
        end
    end

    // Walks the 16 clear cycles starting at the current cycle, then checks o_Ready.
    task automatic check_clear(input bit with_nc);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("clr_wen", {31'b0, w_en}, 1);
            check("clr_waddr", {28'b0, w_addr}, i);
            check("clr_wdata", {24'b0, w_data}, {24'b0, CLR});
            check("clr_gnt", {30'b0, gnt1, gnt0}, 0);
            check("clr_ready", {31'b0, ready}, 0);
            if (with_nc && i == 0) begin
                check("nc_first_gnt0", {31'b0, d1_gnt0}, 1);
                check("nc_ready_early", {31'b0, d1_ready}, 0);
            end
            if (with_nc && i == 1) check("nc_ready", {31'b0, d1_ready}, 1);
            next_cycle();
        end
    endtask

    initial begin
        logic [7:0] d1, d2;

        // Reset with both ports already requesting reads.
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", {31'b0, ready}, 0);
            check("rst_wen", {31'b0, w_en}, 0);
            check("rst_nc_gnt", {30'b0, d1_gnt1, d1_gnt0}, 0);
            next_cycle();
        end
        rst = 1'b0;
        check_clear(1'b1);

        // First arbitration cycle: port 0 wins the tie.
        @(negedge clk);
        check("arb_ready", {31'b0, ready}, 1);
        check("first_gnt0", {31'b0, gnt0}, 1);
        check("first_ren", {31'b0, r_en}, 1);
        check("first_raddr", {28'b0, r_addr}, 7);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        check("second_gnt1", {31'b0, gnt1}, 1);
        check("second_raddr", {28'b0, r_addr}, 2);
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        check("idle_en", {30'b0, w_en, r_en}, 0);
        check("idle_addr", {24'b0, w_addr, r_addr}, 0);
        check("idle_wdata", {24'b0, w_data}, 0);
        next_cycle();

        // Port 0 writes, port 1 reads the same location the next cycle.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 8'h3C;
        @(negedge clk);
        check("wr_gnt0", {31'b0, gnt0}, 1);
        check("wr_wen", {31'b0, w_en}, 1);
        check("wr_waddr", {28'b0, w_addr}, 4);
        check("wr_wdata", {24'b0, w_data}, 8'h3C);
        next_cycle();
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd4;
        @(negedge clk);
        check("raw_gnt1", {31'b0, gnt1}, 1);
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        next_cycle();

        // Port 1 seeds addresses 1 and 2 with random data (pointer stays on port 1).
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        for (int k = 0; k < 2; k++) begin
            req1 = 1'b1; we1 = 1'b1;
            addr1 = (k == 0) ? 4'd1 : 4'd2;
            wdata1 = (k == 0) ? d1 : d2;
            @(negedge clk);
            check("seed_gnt1", {31'b0, gnt1}, 1);
            next_cycle();
        end
        req1 = 1'b0; we1 = 1'b0;

        // Continuous contention: grants alternate starting with port 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_gnt0", {31'b0, gnt0}, (k % 2 == 0) ? 1 : 0);
            check("rr_gnt1", {31'b0, gnt1}, (k % 2 == 1) ? 1 : 0);
            check("rr_raddr", {28'b0, r_addr}, (k % 2 == 0) ? 1 : 2);
            next_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        next_cycle();

        // Reset lands in the cycle after a port-1 read grant.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        @(negedge clk);
        check("pre_rst_gnt1", {31'b0, gnt1}, 1);
        next_cycle();
        req1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wen", {31'b0, w_en}, 0);
        next_cycle();
        rst = 1'b0;
        check_clear(1'b0);

        // Clear overwrote the seeded data at address 2.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        @(negedge clk);
        check("post_clr_ready", {31'b0, ready}, 1);
        check("post_clr_gnt0", {31'b0, gnt0}, 1);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
